srff_bank_scheduler: RTL and testbench
======================================

# srff_bank_scheduler

Round-robin scheduler that shares one bank of NBITS SR flip-flop flags between NREQ requesters. Each requester issues set/clear commands against a flag index over a valid/ready handshake. The scheduler grants one command at a time and drives a single-cycle, one-hot s or r pulse into the bank. It guarantees the forbidden s=r=1 input combination never reaches any cell, and reports completion with the granted requester id. It sits between control agents and status-flag storage.

## Interface
- NREQ, 4, number of requesters (2..8)
- NBITS, 8, number of SR flags in the bank (1..32)
- IDXW, $clog2(NBITS) (min 1), flag index width
- IDW, $clog2(NREQ), requester id width
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset; one clock
- req_valid  in  NREQ  per-requester command valid
- req_op  in  NREQ  per-requester op: 1 = set, 0 = clear
- req_idx  in  NREQ*IDXW  per-requester flag index, requester k at bits [k*IDXW +: IDXW]
- req_ready  out  NREQ  one-hot grant/accept, combinational
- q  out  NBITS  current flag values
- busy  out  1  scheduler in APPLY state
- done  out  1  single-cycle completion pulse
- done_id  out  IDW  requester whose command completed
- done_changed  out  1  with done: the flag value actually changed
- done_err  out  1  with done: index was >= NBITS, so no flag was touched

## Operation
- FSM has two states: IDLE and APPLY.
- **IDLE:**
  - If any req_valid is high, the winner is the first valid requester at or after rr_ptr, searching upward with wrap.
  - req_ready[winner]=1 for that cycle; all other ready bits are 0.
  - On the clock edge, latch {winner, op, idx} and go to APPLY.
  - If no request is valid, stay in IDLE with req_ready all 0.
- **APPLY:**
  - req_ready is all 0 and busy=1.
  - If idx < NBITS, drive s_vec[idx]=op and r_vec[idx]=~op. All other bits stay 0.
  - If idx >= NBITS, s_vec and r_vec stay all 0 and the error is recorded.
  - On the edge: return to IDLE, set rr_ptr=(winner+1) mod NREQ, and register the done outputs.
- **Bank behaviour per bit:**
  - s=1 sets the flag to 1; r=1 clears it to 0; s=r=0 holds.
  - The scheduler never drives s=r=1 on any bit.
- **done_changed** is 1 when the flag's pre-APPLY value differs from the value being written, and 0 for a redundant op or an error.
- The handshake is non-revocable once accepted. A requester may change or drop valid at any time before acceptance.
- A requester that keeps valid high across a grant is re-queued and waits its next round-robin turn.
- **Reset (asynchronous):**
  - Clears q, rr_ptr, the latched command, done, done_id, done_changed and done_err to 0.
  - Puts the FSM in IDLE and forces s_vec and r_vec to 0.
  - A command accepted before reset is discarded and gets no done pulse.

## Timing
- Accept at cycle T, the cycle where valid & ready is high.
- s/r pulse is driven during T+1.
- q reflects the new value from T+2.
- done, done_id, done_changed and done_err are valid during T+2 only.
- Peak throughput is one command per 2 cycles: a new accept may occur in T+2, the same cycle as done.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once every 2*NREQ cycles.
- req_ready depends combinationally on req_valid, rr_ptr and state only; there is no path from req_op or req_idx.

## Structure
- Package srff_sched_pkg holds:
  - OP_CLEAR=1'b0 and OP_SET=1'b1
  - state typedef {IDLE, APPLY}
- Sub-module srff_cell: one SR flip-flop with clock, reset, s, r and q.
  - Asynchronous reset to q=0.
  - Instantiated NBITS times through generate.
  - Holds on 00; its 11 behaviour is unreachable from this block.
- Round-robin pick is a combinational function in the scheduler body, not a separate module.
- Bench assertion checks that (s_vec & r_vec) == 0 every cycle.

## Test plan
- **Single set:** requester 2 valid, op=1, idx=5 from reset. Required: ready[2] at T; s_vec=8'h20 at T+1; q=8'h20 from T+2; done=1, done_id=2, done_changed=1 at T+2.
- **Redundant and clear:**
  - Set idx 5 twice. Required: second done_changed=0, q unchanged.
  - Then clear idx 5. Required: r_vec=8'h20 for one cycle, q=0, done_changed=1.
- **Round-robin:** all four requesters continuously valid, each with a distinct idx. Required:
  - Grants in order 0,1,2,3,0, spaced 2 cycles apart.
  - No requester granted twice within 8 cycles.
- **Pointer wrap:** after a grant to 3, requesters 0 and 3 both valid. Required: 0 granted first.
- **Out-of-range:** NBITS=6, idx=7. Required: s_vec and r_vec stay 0, q unchanged, done_err=1, done_changed=0.
- **Reset mid-operation:** assert reset asynchronously during APPLY for a set of idx 1. Required:
  - q=0 and FSM in IDLE immediately.
  - No done pulse.
  - First grant after release goes to requester 0 if valid.

Source files
------------

// File: rtl/srff_sched_pkg.sv
// Shared constants and FSM state type for the SR-flag bank scheduler.
package srff_sched_pkg;

    localparam logic OP_CLEAR = 1'b0;
    localparam logic OP_SET   = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } state_t;

endpackage

// File: rtl/srff_cell.sv
// Single SR flag: s sets, r clears, 00 holds; 11 is never driven by the scheduler and holds.
module srff_cell (
    input  logic clock,
    input  logic reset,
    input  logic s,
    input  logic r,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (s && !r) begin
            q_d = 1'b1;
        end else if (r && !s) begin
            q_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/srff_bank_scheduler.sv
// Round-robin arbiter that applies one set/clear command at a time to a bank of SR flags,
// producing a one-hot s or r pulse and a registered completion report.
module srff_bank_scheduler
    import srff_sched_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NBITS = 8,
    parameter int unsigned IDXW  = (NBITS > 1) ? $clog2(NBITS) : 1,
    parameter int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_op,
    input  logic [NREQ*IDXW-1:0] req_idx,
    output logic [NREQ-1:0]      req_ready,
    output logic [NBITS-1:0]     q,
    output logic                 busy,
    output logic                 done,
    output logic [IDW-1:0]       done_id,
    output logic                 done_changed,
    output logic                 done_err
);

    localparam int unsigned IDX_SPAN = 1 << IDXW;

    state_t            state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    id_q, id_d;
    logic              op_q, op_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              done_q, done_d;
    logic [IDW-1:0]    done_id_q, done_id_d;
    logic              done_changed_q, done_changed_d;
    logic              done_err_q, done_err_d;

    logic [IDW-1:0]    winner;
    logic              accept;
    logic [NBITS-1:0]  hit;
    logic [NBITS-1:0]  s_vec;
    logic [NBITS-1:0]  r_vec;
    logic [NBITS-1:0]  q_bits;

    // First valid requester at or after ptr, searching upward with wrap.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                               input logic [IDW-1:0]  ptr);
        logic [IDW-1:0] pick;
        logic           found;
        int unsigned    cand;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(ptr) + k) % NREQ;
            if (!found && valid[IDW'(cand)]) begin
                pick  = IDW'(cand);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign winner = rr_pick(req_valid, rr_ptr_q);
    assign accept = (state_q == IDLE) && (|req_valid);

    // Out-of-range indices shift the one-hot past NBITS and truncate to zero.
    assign hit = NBITS'(IDX_SPAN'(1) << idx_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req_valid) state_d = APPLY;
            APPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        s_vec     = '0;
        r_vec     = '0;
        case (state_q)
            IDLE: begin
                if (|req_valid) req_ready[winner] = 1'b1;
            end
            APPLY: begin
                busy = 1'b1;
                if (op_q == OP_SET) s_vec = hit;
                else                r_vec = hit;
            end
            default: ;
        endcase
    end

    // Command latch, pointer advance and completion report.
    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        id_d           = id_q;
        op_d           = op_q;
        idx_d          = idx_q;
        done_d         = 1'b0;
        done_id_d      = done_id_q;
        done_changed_d = 1'b0;
        done_err_d     = 1'b0;
        if (accept) begin
            id_d  = winner;
            op_d  = req_op[winner];
            idx_d = req_idx[winner*IDXW +: IDXW];
        end
        if (state_q == APPLY) begin
            rr_ptr_d       = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
            done_d         = 1'b1;
            done_id_d      = id_q;
            done_changed_d = |(hit & (q_bits ^ {NBITS{op_q}}));
            done_err_d     = ~|hit;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q       <= '0;
            id_q           <= '0;
            op_q           <= 1'b0;
            idx_q          <= '0;
            done_q         <= 1'b0;
            done_id_q      <= '0;
            done_changed_q <= 1'b0;
            done_err_q     <= 1'b0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            id_q           <= id_d;
            op_q           <= op_d;
            idx_q          <= idx_d;
            done_q         <= done_d;
            done_id_q      <= done_id_d;
            done_changed_q <= done_changed_d;
            done_err_q     <= done_err_d;
        end
    end

    for (genvar g = 0; g < NBITS; g++) begin : g_bank
        srff_cell u_cell (
            .clock (clock),
            .reset (reset),
            .s     (s_vec[g]),
            .r     (r_vec[g]),
            .q     (q_bits[g])
        );
    end

    assign q            = q_bits;
    assign done         = done_q;
    assign done_id      = done_id_q;
    assign done_changed = done_changed_q;
    assign done_err     = done_err_q;

endmodule

// File: tb/tb_srff_bank_scheduler.sv
// Scoreboard bench for srff_bank_scheduler: an 8-flag instance and a 6-flag instance for range errors.
module tb_srff_bank_scheduler;
    import srff_sched_pkg::*;

    typedef struct packed {
        logic [1:0] id;
        logic       changed;
        logic       err;
        logic [7:0] q;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst8, rst6;
    logic [3:0]  v8, op8, v6, op6;
    logic [11:0] ix8, ix6;
    logic [3:0]  ready8, ready6;
    logic [7:0]  q8;
    logic [5:0]  q6;
    logic        busy8, busy6, done8, done6, chg8, chg6, err8, err6;
    logic [1:0]  did8, did6;

    exp_t        sb8[$];
    exp_t        sb6[$];
    exp_t        e8, e6;
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    logic [7:0]  m_q8;
    logic [5:0]  m_q6;

    localparam logic [2:0] OOR_IDX [4] = '{3'd2, 3'd7, 3'd6, 3'd5};
    localparam logic       OOR_OP  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    localparam logic [5:0] OOR_S   [4] = '{6'h04, 6'h00, 6'h00, 6'h20};
    localparam logic [5:0] OOR_QB  [4] = '{6'h00, 6'h04, 6'h04, 6'h04};
    localparam logic [5:0] OOR_QA  [4] = '{6'h04, 6'h04, 6'h04, 6'h24};
    localparam logic       OOR_ERR [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic       OOR_CHG [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    srff_bank_scheduler #(.NREQ(4), .NBITS(8)) dut8 (
        .clock(clock), .reset(rst8), .req_valid(v8), .req_op(op8), .req_idx(ix8),
        .req_ready(ready8), .q(q8), .busy(busy8), .done(done8), .done_id(did8),
        .done_changed(chg8), .done_err(err8)
    );

    srff_bank_scheduler #(.NREQ(4), .NBITS(6)) dut6 (
        .clock(clock), .reset(rst6), .req_valid(v6), .req_op(op6), .req_idx(ix6),
        .req_ready(ready6), .q(q6), .busy(busy6), .done(done6), .done_id(did6),
        .done_changed(chg6), .done_err(err6)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req8(input int k, input logic op, input logic [2:0] idx);
        v8[k]           = 1'b1;
        op8[k]          = op;
        ix8[k*3 +: 3]   = idx;
    endtask

    task automatic set_req6(input int k, input logic op, input logic [2:0] idx);
        v6[k]           = 1'b1;
        op6[k]          = op;
        ix6[k*3 +: 3]   = idx;
    endtask

    // Model update plus scoreboard push for an accepted command.
    task automatic expect8(input logic [1:0] k, input logic op, input logic [2:0] idx);
        exp_t e;
        e.id      = k;
        e.changed = (m_q8[idx] != op);
        e.err     = 1'b0;
        m_q8[idx] = op;
        e.q       = m_q8;
        sb8.push_back(e);
    endtask

    task automatic expect6(input logic [1:0] k, input logic op, input logic [2:0] idx);
        exp_t e;
        e.id      = k;
        e.err     = (idx >= 3'd6);
        e.changed = 1'b0;
        if (!e.err) begin
            e.changed = (m_q6[idx] != op);
            m_q6[idx] = op;
        end
        e.q = {2'b00, m_q6};
        sb6.push_back(e);
    endtask

    // Completion scoreboards and s/r exclusivity check, sampled mid-cycle.
    always @(negedge clock) begin
        n_cmp++;
        if ((dut8.s_vec & dut8.r_vec) !== 8'h00) begin
            n_fail++;
            $display("FAIL sr_exclusive8: s&r=%h required 00", dut8.s_vec & dut8.r_vec);
        end
        n_cmp++;
        if ((dut6.s_vec & dut6.r_vec) !== 6'h00) begin
            n_fail++;
            $display("FAIL sr_exclusive6: s&r=%h required 00", dut6.s_vec & dut6.r_vec);
        end
        if (!rst8 && done8 === 1'b1) begin
            n_cmp++;
            if (sb8.size() == 0) begin
                n_fail++;
                $display("FAIL done8_unexpected: done with no pending command at %0t", $time);
            end else begin
                e8 = sb8.pop_front();
                if ({did8, chg8, err8, q8} !== {e8.id, e8.changed, e8.err, e8.q}) begin
                    n_fail++;
                    $display("FAIL done8_report: id/chg/err/q=%0d/%b/%b/%h required %0d/%b/%b/%h",
                             did8, chg8, err8, q8, e8.id, e8.changed, e8.err, e8.q);
                end
            end
        end
        if (!rst6 && done6 === 1'b1) begin
            n_cmp++;
            if (sb6.size() == 0) begin
                n_fail++;
                $display("FAIL done6_unexpected: done with no pending command at %0t", $time);
            end else begin
                e6 = sb6.pop_front();
                if ({did6, chg6, err6, 2'b00, q6} !== {e6.id, e6.changed, e6.err, e6.q}) begin
                    n_fail++;
                    $display("FAIL done6_report: id/chg/err/q=%0d/%b/%b/%h required %0d/%b/%b/%h",
                             did6, chg6, err6, q6, e6.id, e6.changed, e6.err, e6.q[5:0]);
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge clock);
        n_cmp++;
        if ({q8, busy8, done8, ready8, q6, done6} !== {8'h00, 1'b0, 1'b0, 4'h0, 6'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: q8=%h busy=%b done=%b ready=%b q6=%h required 00/0/0/0000/00",
                     q8, busy8, done8, ready8, q6);
        end
        tick();
        rst8 = 1'b0;
        rst6 = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({q8, busy8, done8, ready8} !== {8'h00, 1'b0, 1'b0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_release: q8=%h busy=%b done=%b ready=%b required 00/0/0/0000",
                     q8, busy8, done8, ready8);
        end
    endtask

    task automatic test_single_set();
        tick();
        set_req8(2, OP_SET, 3'd5);
        @(negedge clock);
        n_cmp++;
        if ({ready8, busy8} !== {4'b0100, 1'b0}) begin
            n_fail++;
            $display("FAIL single_grant: ready=%b busy=%b required 0100/0", ready8, busy8);
        end
        expect8(2'd2, OP_SET, 3'd5);
        tick();
        v8 = '0;
        @(negedge clock);
        n_cmp++;
        if ({dut8.s_vec, dut8.r_vec, busy8, ready8, q8} !== {8'h20, 8'h00, 1'b1, 4'h0, 8'h00}) begin
            n_fail++;
            $display("FAIL single_pulse: s=%h r=%h busy=%b ready=%b q=%h required 20/00/1/0000/00",
                     dut8.s_vec, dut8.r_vec, busy8, ready8, q8);
        end
        tick();
        @(negedge clock);
        n_cmp++;
        if ({q8, done8, did8, chg8, busy8} !== {8'h20, 1'b1, 2'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_done: q=%h done=%b id=%0d chg=%b busy=%b required 20/1/2/1/0",
                     q8, done8, did8, chg8, busy8);
        end
    endtask

    task automatic test_redundant_clear();
        for (int i = 0; i < 2; i++) begin
            logic       op;
            logic [7:0] exp_s, exp_r, exp_q;
            logic       exp_chg;
            op      = (i == 0) ? OP_SET : OP_CLEAR;
            exp_s   = (i == 0) ? 8'h20 : 8'h00;
            exp_r   = (i == 0) ? 8'h00 : 8'h20;
            exp_q   = (i == 0) ? 8'h20 : 8'h00;
            exp_chg = (i == 0) ? 1'b0 : 1'b1;
            tick();
            set_req8(2, op, 3'd5);
            @(negedge clock);
            n_cmp++;
            if (ready8 !== 4'b0100) begin
                n_fail++;
                $display("FAIL redund_grant%0d: ready=%b required 0100", i, ready8);
            end
            expect8(2'd2, op, 3'd5);
            tick();
            v8 = '0;
            @(negedge clock);
            n_cmp++;
            if ({dut8.s_vec, dut8.r_vec, q8} !== {exp_s, exp_r, 8'h20}) begin
                n_fail++;
                $display("FAIL redund_pulse%0d: s=%h r=%h q=%h required %h/%h/20",
                         i, dut8.s_vec, dut8.r_vec, q8, exp_s, exp_r);
            end
            tick();
            @(negedge clock);
            n_cmp++;
            if ({q8, done8, chg8} !== {exp_q, 1'b1, exp_chg}) begin
                n_fail++;
                $display("FAIL redund_done%0d: q=%h done=%b chg=%b required %h/1/%b",
                         i, q8, done8, chg8, exp_q, exp_chg);
            end
        end
    endtask

    task automatic test_pointer_wrap();
        tick();
        set_req8(3, OP_SET, 3'd3);
        @(negedge clock);
        n_cmp++;
        if (ready8 !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrap_first: ready=%b required 1000", ready8);
        end
        expect8(2'd3, OP_SET, 3'd3);
        tick();
        v8 = '0;
        set_req8(0, OP_SET, 3'd6);
        set_req8(3, OP_CLEAR, 3'd3);
        @(negedge clock);
        n_cmp++;
        if ({ready8, busy8} !== {4'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_apply_ready: ready=%b busy=%b required 0000/1", ready8, busy8);
        end
        tick();
        @(negedge clock);
        n_cmp++;
        if ({ready8, done8} !== {4'b0001, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_pick0: ready=%b done=%b required 0001/1", ready8, done8);
        end
        expect8(2'd0, OP_SET, 3'd6);
        tick();
        v8[0] = 1'b0;
        @(negedge clock);
        tick();
        @(negedge clock);
        n_cmp++;
        if (ready8 !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrap_requeue3: ready=%b required 1000", ready8);
        end
        expect8(2'd3, OP_CLEAR, 3'd3);
        tick();
        v8 = '0;
        @(negedge clock);
        tick();
        @(negedge clock);
        n_cmp++;
        if (q8 !== m_q8) begin
            n_fail++;
            $display("FAIL wrap_q: q=%h required %h", q8, m_q8);
        end
    endtask

    task automatic test_round_robin();
        int         last [4];
        logic [2:0] ridx [4];
        ridx = '{3'd0, 3'd1, 3'd2, 3'd4};
        for (int k = 0; k < 4; k++) last[k] = -100;
        tick();
        for (int k = 0; k < 4; k++) set_req8(k, OP_SET, ridx[k]);
        for (int c = 0; c < 10; c++) begin
            logic [3:0] exp_ready;
            exp_ready = (c % 2 == 0) ? (4'b0001 << ((c / 2) % 4)) : 4'b0000;
            @(negedge clock);
            n_cmp++;
            if (ready8 !== exp_ready) begin
                n_fail++;
                $display("FAIL rr_grant_c%0d: ready=%b required %b", c, ready8, exp_ready);
            end
            for (int k = 0; k < 4; k++) begin
                if (ready8[k] === 1'b1) begin
                    n_cmp++;
                    if (c - last[k] < 8) begin
                        n_fail++;
                        $display("FAIL rr_fairness_r%0d: regrant after %0d cycles required >= 8",
                                 k, c - last[k]);
                    end
                    last[k] = c;
                end
            end
            if (exp_ready != 4'b0000) expect8(2'((c / 2) % 4), OP_SET, ridx[(c / 2) % 4]);
            tick();
        end
        v8 = '0;
        @(negedge clock);
        tick();
        @(negedge clock);
        n_cmp++;
        if ({q8, ready8} !== {m_q8, 4'h0}) begin
            n_fail++;
            $display("FAIL rr_final: q=%h ready=%b required %h/0000", q8, ready8, m_q8);
        end
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 4; i++) begin
            tick();
            set_req6(i, OOR_OP[i], OOR_IDX[i]);
            @(negedge clock);
            n_cmp++;
            if (ready6 !== (4'b0001 << i)) begin
                n_fail++;
                $display("FAIL oor_grant%0d: ready=%b required %b", i, ready6, 4'b0001 << i);
            end
            expect6(2'(i), OOR_OP[i], OOR_IDX[i]);
            tick();
            v6 = '0;
            @(negedge clock);
            n_cmp++;
            if ({dut6.s_vec, dut6.r_vec, busy6, q6} !== {OOR_S[i], 6'h00, 1'b1, OOR_QB[i]}) begin
                n_fail++;
                $display("FAIL oor_pulse%0d: s=%h r=%h busy=%b q=%h required %h/00/1/%h",
                         i, dut6.s_vec, dut6.r_vec, busy6, q6, OOR_S[i], OOR_QB[i]);
            end
            tick();
            @(negedge clock);
            n_cmp++;
            if ({q6, done6, err6, chg6} !== {OOR_QA[i], 1'b1, OOR_ERR[i], OOR_CHG[i]}) begin
                n_fail++;
                $display("FAIL oor_done%0d: q=%h done=%b err=%b chg=%b required %h/1/%b/%b",
                         i, q6, done6, err6, chg6, OOR_QA[i], OOR_ERR[i], OOR_CHG[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        tick();
        set_req8(1, OP_SET, 3'd1);
        @(negedge clock);
        n_cmp++;
        if (ready8 !== 4'b0010) begin
            n_fail++;
            $display("FAIL rstmid_grant: ready=%b required 0010", ready8);
        end
        tick();
        v8 = '0;
        #2;
        rst8 = 1'b1;
        m_q8 = 8'h00;
        #1;
        n_cmp++;
        if ({q8, busy8, dut8.s_vec, dut8.r_vec, done8} !== {8'h00, 1'b0, 8'h00, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_async: q=%h busy=%b s=%h r=%h done=%b required 00/0/00/00/0",
                     q8, busy8, dut8.s_vec, dut8.r_vec, done8);
        end
        tick();
        rst8 = 1'b0;
        set_req8(0, OP_CLEAR, 3'd0);
        set_req8(3, OP_SET, 3'd7);
        @(negedge clock);
        n_cmp++;
        if ({ready8, done8, q8} !== {4'b0001, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL rstmid_after: ready=%b done=%b q=%h required 0001/0/00", ready8, done8, q8);
        end
        expect8(2'd0, OP_CLEAR, 3'd0);
        tick();
        v8 = '0;
        @(negedge clock);
        tick();
        @(negedge clock);
        n_cmp++;
        if ({done8, did8, chg8, q8} !== {1'b1, 2'd0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL rstmid_done: done=%b id=%0d chg=%b q=%h required 1/0/0/00",
                     done8, did8, chg8, q8);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst8 = 1'b1;
        rst6 = 1'b1;
        v8   = '0;
        op8  = '0;
        ix8  = '0;
        v6   = '0;
        op6  = '0;
        ix6  = '0;
        m_q8 = '0;
        m_q6 = '0;
        test_reset();
        test_single_set();
        test_redundant_clear();
        test_pointer_wrap();
        test_round_robin();
        test_out_of_range();
        test_reset_mid();
        tick();
        @(negedge clock);
        n_cmp++;
        if (sb8.size() != 0 || sb6.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: pending8=%0d pending6=%0d required 0/0",
                     sb8.size(), sb6.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
